// File: rtl/load_store_unit_pkg.sv
// Package for the load/store unit.
// Holds the LSU FSM state type and the base byte-enable pattern for each
// access size (shifted into place by the access offset).
`include "inst_defs.sv"

package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_t;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

endpackage

// File: rtl/inst_defs.sv
// Shared instruction-field definitions for the core.
// Provides register/funct3 range macros, opcode macros and the funct3
// encodings for the RV32I load/store instructions.
`ifndef INST_DEFS_SV
`define INST_DEFS_SV

`define REG_RANGE    31:0
`define FUNCT__RANGE 2:0

`define OP_LOAD  7'b0000011
`define OP_STORE 7'b0100011

`define F3_LB  3'b000
`define F3_LH  3'b001
`define F3_LW  3'b010
`define F3_LBU 3'b100
`define F3_LHU 3'b101

`define F3_SB  3'b000
`define F3_SH  3'b001
`define F3_SW  3'b010

`endif

// File: rtl/load_store_unit_align.sv
// Combinational lane logic for the load/store unit.
// Request side : i_funct3, i_is_store, i_addr_lo, i_wdata
//                -> o_be (byte enables), o_wdata (lane-aligned store data),
//                   o_misaligned (access rejected: bad alignment or funct3)
// Load side    : i_ld_funct3, i_ld_addr_lo, i_rdata
//                -> o_ld_data (selected lane, sign/zero extended)
`include "inst_defs.sv"

module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [`FUNCT__RANGE] i_funct3,
  input  logic                 i_is_store,
  input  logic [1:0]           i_addr_lo,
  input  logic [`REG_RANGE]    i_wdata,
  input  logic [`FUNCT__RANGE] i_ld_funct3,
  input  logic [1:0]           i_ld_addr_lo,
  input  logic [`REG_RANGE]    i_rdata,
  output logic [3:0]           o_be,
  output logic [`REG_RANGE]    o_wdata,
  output logic                 o_misaligned,
  output logic [`REG_RANGE]    o_ld_data
);

  logic [`REG_RANGE] w_rshift;

  // Store encodings SB/SH/SW share values with LB/LH/LW, so one case covers
  // both; the unsigned variants exist only for loads.
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = '0;
    o_misaligned = 1'b0;
    case (i_funct3)
      `F3_LB: begin
        o_be    = BE_B << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      `F3_LH: begin
        o_be         = BE_H << i_addr_lo;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      `F3_LW: begin
        o_be         = BE_W;
        o_wdata      = i_wdata;
        o_misaligned = |i_addr_lo;
      end
      `F3_LBU: begin
        o_be         = BE_B << i_addr_lo;
        o_misaligned = i_is_store;
      end
      `F3_LHU: begin
        o_be         = BE_H << i_addr_lo;
        o_misaligned = i_is_store | i_addr_lo[0];
      end
      default: o_misaligned = 1'b1;
    endcase
  end

  // Move the addressed lane down to bit 0 before extending.
  assign w_rshift = i_rdata >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    o_ld_data = i_rdata;
    case (i_ld_funct3)
      `F3_LB:  o_ld_data = {{24{w_rshift[7]}}, w_rshift[7:0]};
      `F3_LH:  o_ld_data = {{16{w_rshift[15]}}, w_rshift[15:0]};
      `F3_LBU: o_ld_data = {24'h0, w_rshift[7:0]};
      `F3_LHU: o_ld_data = {16'h0, w_rshift[15:0]};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: core-side initiator for data-memory accesses.
// Pipeline side : req_valid/req_is_store/funct3/req_addr/req_wdata in,
//                 busy (stall), done (pulse), load_data, misaligned (pulse).
// Memory side   : mem_req/mem_we/mem_addr (word)/mem_be/mem_wdata out,
//                 mem_gnt/mem_rvalid/mem_rdata in.
// Debug         : dbg_state exposes the FSM state.
//
// Handshakes: a pipeline request is taken only in IDLE outside the
// misaligned pulse cycle; at other times req_valid is ignored and the
// pipeline holds it while busy is high. mem_req stays high with stable
// address/we/be/wdata until the cycle mem_gnt is sampled high. After a load
// grant the unit accepts exactly one mem_rvalid; rvalid in any other state
// is ignored.
`include "inst_defs.sv"

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_is_store,
  input  logic [`FUNCT__RANGE] funct3,
  input  logic [`REG_RANGE]    req_addr,
  input  logic [`REG_RANGE]    req_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [`REG_RANGE]    load_data,
  output logic                 misaligned,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [`REG_RANGE]    mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [`REG_RANGE]    mem_rdata,
  output logic [1:0]           dbg_state
);

  lsu_state_t           r_state;
  lsu_state_t           w_next;
  logic [`FUNCT__RANGE] r_funct3;
  logic [1:0]           r_addr_lo;
  logic                 r_is_store;
  logic                 r_misaligned;
  logic [ADDR_BITS-1:0] r_mem_addr;
  logic [3:0]           r_mem_be;
  logic [`REG_RANGE]    r_mem_wdata;
  logic [`REG_RANGE]    r_load_data;

  logic                 w_accept;
  logic                 w_reject;
  logic [3:0]           w_be;
  logic [`REG_RANGE]    w_wdata;
  logic                 w_misaligned;
  logic [`REG_RANGE]    w_ld_data;
  logic                 w_unused;

  // Byte address bits above the word address are not used by this memory.
  assign w_unused = ^req_addr[WIDTH-1:ADDR_BITS+2];

  lsu_align u_align (
    .i_funct3     (funct3),
    .i_is_store   (req_is_store),
    .i_addr_lo    (req_addr[1:0]),
    .i_wdata      (req_wdata),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .o_ld_data    (w_ld_data)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && !r_misaligned) begin
          if (w_misaligned) begin
            w_reject = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = S_REQ;
          end
        end
      end
      S_REQ:    if (mem_gnt) w_next = r_is_store ? S_RESP : S_WAIT_R;
      S_WAIT_R: if (mem_rvalid) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
      r_is_store   <= 1'b0;
      r_misaligned <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= '0;
      r_mem_wdata  <= '0;
      r_load_data  <= '0;
    end else begin
      r_state      <= w_next;
      r_misaligned <= w_reject;
      if (w_accept) begin
        r_funct3    <= funct3;
        r_addr_lo   <= req_addr[1:0];
        r_is_store  <= req_is_store;
        r_mem_addr  <= req_addr[ADDR_BITS+1:2];
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
      end
      if (r_state == S_WAIT_R && mem_rvalid) begin
        r_load_data <= w_ld_data;
      end
    end
  end

  assign mem_req    = (r_state == S_REQ);
  assign mem_we     = (r_state == S_REQ) && r_is_store;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;
  assign done       = (r_state == S_RESP);
  assign misaligned = r_misaligned;
  assign busy       = (r_state != S_IDLE) || r_misaligned;
  assign load_data  = r_load_data;
  assign dbg_state  = r_state;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for data-memory accesses. It accepts one load or store per transaction from the execute/memory stage and checks alignment. It drives a request/grant/response handshake to the data memory, using word addresses, byte enables and lane-shifted store data. On loads it returns the byte/halfword/word sign- or zero-extended per funct3. The block sits between the pipeline's memory stage and the data memory, and stalls the pipeline while a transaction is outstanding.

## Interface
- `WIDTH`, 32, data/address width
- `ADDR_BITS`, 8, word-address bits driven to memory (256 words)
---
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  pipeline presents a transaction
- `req_is_store`  in  1  1 = store, 0 = load
- `funct3`  in  `FUNCT__RANGE`  LB/LH/LW/LBU/LHU or SB/SH/SW encoding
- `req_addr`  in  `REG_RANGE`  byte address
- `req_wdata`  in  `REG_RANGE`  store data (low bytes significant)
- `busy`  out  1  transaction in flight; pipeline stalls
- `done`  out  1  one-cycle pulse: transaction complete
- `load_data`  out  `REG_RANGE`  extended load result, valid with `done`
- `misaligned`  out  1  one-cycle pulse: access rejected
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write strobe
- `mem_addr`  out  ADDR_BITS  word address = `req_addr[ADDR_BITS+1:2]`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  `REG_RANGE`  lane-aligned store data
- `mem_gnt`  in  1  memory accepts request this cycle
- `mem_rvalid`  in  1  load data valid
- `mem_rdata`  in  `REG_RANGE`  full word read

## Operation
- States: IDLE, REQ, WAIT_R, RESP.
- IDLE: when `req_valid` is high, register addr, funct3, is_store and wdata.
  - If misaligned, pulse `misaligned` next cycle and stay IDLE. H with addr[0]=1 is misaligned; W with addr[1:0]≠0 is misaligned. No memory request is issued.
  - Otherwise go to REQ.
- REQ: `mem_req`=1 with stable addr/we/be/wdata until `mem_gnt`.
  - On a store grant, go to RESP.
  - On a load grant, go to WAIT_R.
- WAIT_R: wait for `mem_rvalid`, then capture the extracted and extended data and go to RESP.
- RESP: `done`=1 for one cycle, then go to IDLE.
- `busy` = (state≠IDLE) or the misaligned pulse cycle.
- Byte enables:
  - B: `4'b0001<<addr[1:0]`
  - H: `4'b0011<<addr[1:0]`
  - W: `4'b1111`
  - Loads drive `mem_be` the same way; `mem_we`=0.
- Store data: `req_wdata` replicated/shifted into lane `addr[1:0]`, so that SB of 0xAB at offset 2 gives wdata[23:16]=0xAB.
- Load extract: select the lane by `addr[1:0]`.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Unknown funct3 is treated as misaligned (rejected).
- `req_valid` while busy is ignored; the pipeline holds it.

## Timing
- Reset values: state IDLE; `busy`, `done`, `misaligned`, `mem_req`, `mem_we` = 0; `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `load_data`=0.
- Accept at edge N, so `mem_req` is high from N+1.
- With grant in the same cycle as the request:
  - store `done` at N+2;
  - load with `mem_rvalid` one cycle after grant has `done` and `load_data` at N+3.
- `mem_rvalid` in the same cycle as `mem_gnt` is not allowed; the memory returns data ≥1 cycle after grant.
- `load_data` holds its value until the next load completes.
- Reset mid-transaction returns to IDLE at the next edge and drops `mem_req`. Any `mem_rvalid` arriving in IDLE is ignored.
- `done` and `misaligned` are never high together.

## Structure
- Funct3/opcode macros and `REG_RANGE`/`FUNCT__RANGE` come from `inst_defs.sv`.
- Add to the shared package:
  - the LSU state enum `lsu_state_t`;
  - a `BE_*` constant per access size.
- Sub-module `lsu_align`: combinational `be`, wdata lane shift, load extract/extend, and misalignment check. The FSM and registers stay in `load_store_unit`.

## Test plan
- SW 0xDEADBEEF @0x10, grant immediately:
  - `mem_addr`=4, `mem_be`=1111, `mem_we`=1;
  - `done` 2 cycles after accept.
- LB @0x13, `mem_rdata`=0x80FF_0000, rvalid 1 cycle after grant: `mem_be`=1000; `load_data`=0xFFFFFF80 on `done`. LBU on the same data gives 0x00000080.
- SH 0x1234 @0x06: `mem_be`=1100, `mem_wdata[31:16]`=0x1234. A following LHU @0x06 returning 0x1234_xxxx gives 0x00001234.
- LW @0x02: `misaligned` pulses next cycle, `mem_req` never asserts, `done` stays 0.
- Grant delayed 3 cycles: `mem_req`, `mem_addr` and `mem_be` are stable throughout and `busy` stays high. `req_valid` toggled during the wait is ignored.
- `reset` asserted in WAIT_R:
  - next cycle state is IDLE with all outputs at reset values;
  - a late `mem_rvalid` yields no `done`.
